// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Stream layout: one count byte, 2N instruction bytes, one XOR checksum byte.
package loader_pkg;

    typedef enum logic [2:0] {
        StCount,
        StHi,
        StLo,
        StWrite,
        StChk,
        StRun,
        StErr
    } ldr_state_t;

    localparam int unsigned LDR_DEPTH_DEF = 100;
    localparam int unsigned LDR_CHK_W     = 8;
    localparam int unsigned HDR_BYTES     = 1;
    localparam int unsigned TRL_BYTES     = 1;

    // States in which the loader takes a byte from the stream.
    function automatic logic ldr_accepting(input ldr_state_t st);
        return (st == StCount) || (st == StHi) || (st == StLo) || (st == StChk);
    endfunction

endpackage

// File: rtl/xor_accum.sv
// Running 8-bit XOR checksum register with synchronous clear and enable.
module xor_accum
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [LDR_CHK_W-1:0] din,
    output logic [LDR_CHK_W-1:0] acc
);

    logic [LDR_CHK_W-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q ^ din;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ins_loader.sv
// Boot loader: assembles 16-bit words from a byte stream, writes them to instruction
// memory from address 0, and releases the processor only after the checksum verifies.
module ins_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH  = LDR_DEPTH_DEF,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              load_err
);

    ldr_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [7:0]           hi_q, hi_d;
    logic [7:0]           lo_q, lo_d;
    logic [ADDR_W-1:0]    idx_inc;
    logic                 accept;
    logic                 hdr_bad;
    logic                 chk_clr;
    logic                 chk_en;
    logic [LDR_CHK_W-1:0] chk_sum;

    xor_accum u_xor_accum (
        .clk (clk),
        .rst (rst),
        .clr (chk_clr),
        .en  (chk_en),
        .din (byte_data),
        .acc (chk_sum)
    );

    // All outputs decode registered state only; nothing depends combinationally on byte_valid.
    assign byte_ready = ldr_accepting(state_q);
    assign accept     = byte_valid & byte_ready;
    assign idx_inc    = idx_q + ADDR_W'(1);
    assign hdr_bad    = (byte_data == 8'h00) || (32'(byte_data) > DEPTH);

    assign imem_we    = (state_q == StWrite);
    assign imem_addr  = idx_q;
    assign imem_wdata = {hi_q, lo_q};
    assign cpu_run    = (state_q == StRun);
    assign load_done  = (state_q == StRun);
    assign load_err   = (state_q == StErr);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        chk_clr = 1'b0;
        chk_en  = 1'b0;

        unique case (state_q)
            StCount: begin
                if (accept) begin
                    if (hdr_bad) begin
                        state_d = StErr;
                    end else begin
                        cnt_d   = ADDR_W'(byte_data);
                        idx_d   = '0;
                        chk_clr = 1'b1;
                        state_d = StHi;
                    end
                end
            end
            StHi: begin
                if (accept) begin
                    hi_d    = byte_data;
                    chk_en  = 1'b1;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (accept) begin
                    lo_d    = byte_data;
                    chk_en  = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == cnt_q) ? StChk : StHi;
            end
            StChk: begin
                if (accept) begin
                    state_d = (byte_data == chk_sum) ? StRun : StErr;
                end
            end
            StRun:   state_d = StRun;
            StErr:   state_d = StErr;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCount;
            idx_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_ins_loader.sv
// Randomised scoreboard bench for ins_loader: a driver streams loads while a monitor
// checks every memory write against writes predicted from the stream contents.
module tb_ins_loader;
    import loader_pkg::*;

    localparam int unsigned DEPTH  = 100;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_run;
    logic              load_done;
    logic              load_err;

    ins_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next predicted write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                check("ready_low_in_write", 32'(byte_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(imem_addr), 32'(e.addr));
                    check("write_data", 32'(imem_wdata), 32'(e.data));
                end
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one byte from a negedge; returns on the negedge after it is consumed.
    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int unsigned gap;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 1000; t++) begin
            if (byte_ready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: byte %0h never accepted, expected acceptance", b);
    endtask

    // Reference model: a load writes word i to address i for a legal header, and
    // verifies only when the trailer equals the XOR of all instruction bytes.
    task automatic run_load(input logic [7:0] n, input logic [15:0] words[$],
                            input logic [7:0] corrupt, input int unsigned max_gap,
                            input string tag);
        logic [7:0] x;
        logic       hdr_ok;
        logic       pass;
        x      = 8'h00;
        hdr_ok = (n != 8'h00) && (32'(n) <= DEPTH);
        foreach (words[i]) x = x ^ words[i][15:8] ^ words[i][7:0];
        pass = hdr_ok && (corrupt == 8'h00);
        if (hdr_ok) begin
            for (int i = 0; i < int'(n); i++) exp_q.push_back({ADDR_W'(i), words[i]});
        end

        send_byte(n, max_gap);
        if (hdr_ok) begin
            for (int i = 0; i < int'(n); i++) begin
                send_byte(words[i][15:8], max_gap);
                send_byte(words[i][7:0], max_gap);
            end
            send_byte(x ^ corrupt, max_gap);
        end
        byte_valid = 1'b0;
        // Verdict is visible in the cycle right after the last accepted byte.
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'(pass));
        check({tag, "_load_done"}, 32'(load_done), 32'(pass));
        check({tag, "_load_err"}, 32'(load_err), 32'(!pass));
        check({tag, "_ready_low"}, 32'(byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_cpu_run_hold"}, 32'(cpu_run), 32'(pass));
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[$];
        logic [7:0]  n;
        logic [7:0]  c;

        do_reset();
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);

        // Directed 3-word load with checksum 71, then the same with 70.
        w = '{16'h07FF, 16'h8000, 16'h0900};
        run_load(8'd3, w, 8'h00, 0, "valid3");
        do_reset();
        run_load(8'd3, w, 8'h01, 0, "badchk");

        // Header bounds.
        w = {};
        do_reset();
        run_load(8'd0, w, 8'h00, 0, "n0");
        do_reset();
        run_load(8'd101, w, 8'h00, 0, "n101");
        do_reset();
        run_load(8'($urandom_range(255, 102)), w, 8'h00, 0, "nbig");
        for (int i = 0; i < 100; i++) w.push_back(16'($urandom));
        do_reset();
        run_load(8'd100, w, 8'h00, 0, "n100");

        // Gap-free vs gapped loads of identical content must produce identical writes.
        w = {};
        for (int i = 0; i < 6; i++) w.push_back(16'($urandom));
        do_reset();
        run_load(8'd6, w, 8'h00, 0, "nogap");
        do_reset();
        run_load(8'd6, w, 8'h00, 4, "gaps");

        // Reset coincident with the low byte of word 1: that word is never written.
        do_reset();
        w = '{16'hA55A, 16'h1234};
        exp_q.push_back({ADDR_W'(0), 16'hA55A});
        send_byte(8'd2, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        send_byte(8'h12, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h34;
        rst        = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        byte_valid = 1'b0;
        check("midrst_ready", 32'(byte_ready), 32'd1);
        check("midrst_cpu_run", 32'(cpu_run), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_load(8'd2, w, 8'h00, 0, "afterrst");

        // Reset while running drops cpu_run one cycle later.
        rst = 1'b1;
        @(negedge clk);
        check("runrst_cpu_run", 32'(cpu_run), 32'd0);
        check("runrst_load_done", 32'(load_done), 32'd0);
        check("runrst_ready", 32'(byte_ready), 32'd1);
        rst = 1'b0;

        // Randomised loads with occasional corrupted trailers.
        for (int k = 0; k < 8; k++) begin
            n = 8'($urandom_range(12, 1));
            c = ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            w = {};
            for (int i = 0; i < int'(n); i++) w.push_back(16'($urandom));
            do_reset();
            run_load(n, w, c, $urandom_range(3, 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ins_loader.md
# ins_loader

Boot-time program loader sitting directly upstream of the instruction memory and the processor. It accepts a byte stream (count, instruction bytes, checksum) over a valid/ready handshake and assembles 16-bit instructions. It writes them to consecutive instruction-memory addresses starting at 0. It releases the processor (`cpu_run`) only after a verified load; until then the processor is held with its PC at 0.

## Interface
- `DEPTH`, 100: instruction-memory depth in words; maximum loadable word count.
- `ADDR_W`, 8: instruction-memory address width.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `byte_valid` input 1: source presents `byte_data`.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle; transfer when `byte_valid & byte_ready` at rising edge.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output ADDR_W: write address.
- `imem_wdata` output 16: instruction word, `{hi_byte, lo_byte}`.
- `cpu_run` output 1: processor enable; 0 holds PC at 0 and suppresses all processor writes.
- `load_done` output 1: level, load verified.
- `load_err` output 1: level, load rejected.

## Operation
- **Stream format:**
  - byte 0: word count N.
  - Then N pairs, high byte first, then low byte.
  - Then one checksum byte, equal to the XOR of all 2N instruction bytes (the count is excluded).
- **States:** COUNT, HI, LO, WRITE, CHK, RUN, ERR.
- **COUNT** (`byte_ready`=1):
  - On accept, N==0 or N>DEPTH goes to ERR.
  - Otherwise: latch N, clear the word index and checksum, go to HI.
- **HI** (`byte_ready`=1): on accept, latch the high byte, XOR it into the checksum, go to LO.
- **LO** (`byte_ready`=1): on accept, latch the low byte, XOR it into the checksum, go to WRITE.
- **WRITE** (`byte_ready`=0):
  - `imem_we`=1 for exactly this cycle, with `imem_addr`=index and `imem_wdata`={hi,lo}.
  - Then increment the index.
  - If the incremented index equals N, go to CHK; otherwise go to HI.
- **CHK** (`byte_ready`=1):
  - On accept, a byte equal to the checksum goes to RUN; otherwise go to ERR.
- **RUN:**
  - `cpu_run`=1, `load_done`=1, `byte_ready`=0.
  - Terminal until `rst`.
- **ERR:**
  - `load_err`=1, `cpu_run`=0, `byte_ready`=0.
  - Terminal until `rst`.
- **Index arithmetic:** the index is ADDR_W bits and never wraps, because N≤DEPTH≤2^ADDR_W−1.
- **Checksum:** 8-bit XOR, no carry.
- **Idle source:** `byte_valid`=0 in any accepting state leaves all state unchanged; there is no timeout.
- **Bytes arriving in non-accepting states:** ignored (not consumed); the source must hold them.

## Timing
- **Reset values:** state=COUNT, `byte_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `load_done`=0, `load_err`=0, index=0, checksum=0.
- **Reset mid-load:** returns to COUNT on the next edge. Words already written remain in memory, but `cpu_run` stays 0 until a complete new load verifies.
- **Reset in RUN:** drops `cpu_run` in the cycle after the edge, restarting the processor hold.
- **Throughput:** 3 cycles per word minimum (HI, LO, WRITE).
- **Write latency:** the write occurs in the cycle after the low byte is accepted.
- **Release latency:** `cpu_run` rises in the cycle after the checksum byte is accepted.
- **Registered outputs:** `byte_ready` is a registered state decode; there is no combinational path from `byte_valid` to `byte_ready`.
- **Simultaneous `rst` and accepted byte:** `rst` wins and the byte is dropped.
- **Source side:** `byte_valid` may stay high continuously; a byte is consumed only on a handshake.

## Structure
- **Shared package `loader_pkg`:**
  - State enum `ldr_state_t`.
  - `LDR_DEPTH_DEF`=100.
  - `LDR_CHK_W`=8.
  - Stream-format constants (`HDR_BYTES`=1, `TRL_BYTES`=1).
- **Sub-module `xor_accum`:** 8-bit checksum register with `clr` and `en` inputs.
- **Everything else in `ins_loader`:**
  - FSM.
  - Index counter.
  - hi/lo byte latches.

## Test plan
- **Valid 3-word load:**
  - Stimulus: stream 03, 07 FF, 80 00, 09 00, checksum 07^FF^80^00^09^00=71.
  - Response: writes 07FF@0, 8000@1, 0900@2, each with a one-cycle `imem_we`; then `cpu_run`=`load_done`=1, `load_err`=0.
- **Bad checksum:**
  - Stimulus: same stream with checksum 70.
  - Response: three writes occur, then `load_err`=1, `cpu_run`=0, `byte_ready`=0.
- **Header bounds:**
  - Stimulus: N=00, and separately N=65 (101).
  - Response: ERR immediately, no `imem_we` pulse.
  - Stimulus: N=64 (100) with a valid stream.
  - Response: last write at address 99 (0x63), then RUN.
- **Backpressure and gaps:**
  - Stimulus: `byte_valid` held high continuously.
  - Response: `byte_ready` low in each WRITE cycle and no byte lost.
  - Stimulus: random idle gaps.
  - Response: identical memory contents to the gap-free load.
- **Reset mid-load and after RUN:**
  - Stimulus: `rst` after the LO byte of word 1.
  - Response: no write for the interrupted word, state COUNT, `cpu_run`=0; a following valid load reaches RUN.
  - Stimulus: `rst` while in RUN.
  - Response: `cpu_run` drops next cycle.
